// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : RV32I decode types, opcode constants and ALU-op helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_ALUI    = 4'd7,
        CLS_ALU     = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd11
    } op_class_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        op_class_e   op_class;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic        illegal;
    } decoded_t;

    // alt selects SUB/SRA (funct7 = 0100000) for the two funct3 codes that have it
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e muldiv_alu_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'd0:    op = ALU_MUL;
            3'd1:    op = ALU_MULH;
            3'd2:    op = ALU_MULHSU;
            3'd3:    op = ALU_MULHU;
            3'd4:    op = ALU_DIV;
            3'd5:    op = ALU_DIVU;
            3'd6:    op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_decoder.sv
// ============================================================================
// Module   : rv32_decoder
// Brief    : Combinational RV32I instruction decoder; RV32M_EN adds mul/div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output decoded_t    o_dec
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];
    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u  = {i_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    logic        w_legal;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    op_class_e   w_cls;
    alu_op_e     w_alu;
    logic [31:0] w_imm;

    always_comb begin
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_cls     = CLS_ILLEGAL;
        w_alu     = ALU_ADD;
        w_imm     = '0;
        if (i_inst[1:0] == 2'b11) begin
            case (w_opcode)
                OPC_LUI: begin
                    w_legal = 1'b1; w_cls = CLS_LUI; w_use_rd = 1'b1; w_imm = w_imm_u;
                end
                OPC_AUIPC: begin
                    w_legal = 1'b1; w_cls = CLS_AUIPC; w_use_rd = 1'b1; w_imm = w_imm_u;
                end
                OPC_JAL: begin
                    w_legal = 1'b1; w_cls = CLS_JAL; w_use_rd = 1'b1; w_imm = w_imm_j;
                end
                OPC_JALR: begin
                    w_legal = (w_f3 == 3'd0); w_cls = CLS_JALR;
                    w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm = w_imm_i;
                end
                OPC_BRANCH: begin
                    w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3); w_cls = CLS_BRANCH;
                    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_b;
                end
                OPC_LOAD: begin
                    w_legal = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
                    w_cls = CLS_LOAD; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm = w_imm_i;
                end
                OPC_STORE: begin
                    w_legal = (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd2);
                    w_cls = CLS_STORE; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm = w_imm_s;
                end
                OPC_OP_IMM: begin
                    w_cls = CLS_ALUI; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm = w_imm_i;
                    w_alu = base_alu_op(w_f3, (w_f3 == 3'd5) && (w_f7 == F7_ALT));
                    // shift-immediates reuse the funct7 slot as an encoding check
                    case (w_f3)
                        3'd1:    w_legal = (w_f7 == F7_BASE);
                        3'd5:    w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                        default: w_legal = 1'b1;
                    endcase
                end
                OPC_OP: begin
                    w_cls = CLS_ALU; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                    if (w_f7 == F7_BASE) begin
                        w_legal = 1'b1;
                        w_alu   = base_alu_op(w_f3, 1'b0);
                    end else if (w_f7 == F7_ALT) begin
                        w_legal = (w_f3 == 3'd0) || (w_f3 == 3'd5);
                        w_alu   = base_alu_op(w_f3, 1'b1);
                    end
`ifdef RV32M_EN
                    else if (w_f7 == F7_MULDIV) begin
                        w_legal = 1'b1;
                        w_alu   = muldiv_alu_op(w_f3);
                    end
`endif
                end
                OPC_MISC_MEM: begin
                    w_legal = (w_f3 == 3'd0); w_cls = CLS_FENCE;
                    w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm = w_imm_i;
                end
                OPC_SYSTEM: begin
                    // only ECALL (imm 0) and EBREAK (imm 1) exist in the base ISA
                    w_legal = (w_f3 == 3'd0) && (i_inst[19:7] == 13'd0) && (i_inst[31:21] == 11'd0);
                    w_cls = CLS_SYSTEM; w_imm = w_imm_i;
                end
                default: begin
                    w_legal = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_dec          = '0;
        o_dec.pc       = i_pc;
        o_dec.funct3   = w_f3;
        o_dec.illegal  = !w_legal;
        o_dec.op_class = w_legal ? w_cls : CLS_ILLEGAL;
        o_dec.alu_op   = w_legal ? w_alu : ALU_ADD;
        o_dec.imm      = w_legal ? w_imm : 32'd0;
        o_dec.rs1      = (w_legal && w_use_rs1) ? i_inst[19:15] : 5'd0;
        o_dec.rs2      = (w_legal && w_use_rs2) ? i_inst[24:20] : 5'd0;
        o_dec.rd       = (w_legal && w_use_rd)  ? i_inst[11:7]  : 5'd0;
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode stage with skid buffer, output register and flush.
//            Optional RV32M decoding is enabled by defining RV32M_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instruction,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output op_class_e       id_op_class,
    output alu_op_e         id_alu_op,
    output logic [2:0]      id_funct3,
    output logic            id_illegal
);

    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_inst;
    logic            r_out_valid;
    decoded_t        r_out;

    logic            w_accept;
    logic            w_out_load_en;
    logic [XLEN-1:0] w_src_pc;
    logic [XLEN-1:0] w_src_inst;
    decoded_t        w_dec;

    assign w_accept      = if_valid && if_ready;
    assign w_out_load_en = !r_out_valid || id_ready;

    // skid entry always wins so that program order is kept
    assign w_src_pc   = r_skid_valid ? r_skid_pc   : if_pc;
    assign w_src_inst = r_skid_valid ? r_skid_inst : if_instruction;

    rv32_decoder u_decoder (
        .i_pc   (w_src_pc),
        .i_inst (w_src_inst),
        .o_dec  (w_dec)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (w_out_load_en) begin
            // if_ready is low whenever the skid is full, so no accept can collide here
            if (r_skid_valid) begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_pc    <= if_pc;
            r_skid_inst  <= if_instruction;
            r_skid_valid <= 1'b1;
        end
    end

    assign if_ready    = !r_skid_valid;
    assign id_valid    = r_out_valid;
    assign id_pc       = r_out.pc;
    assign id_rs1      = r_out.rs1;
    assign id_rs2      = r_out.rs2;
    assign id_rd       = r_out.rd;
    assign id_imm      = r_out.imm;
    assign id_op_class = r_out.op_class;
    assign id_alu_op   = r_out.alu_op;
    assign id_funct3   = r_out.funct3;
    assign id_illegal  = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed self-checking bench for decode_stage (RV32M_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;
    import riscv_pkg::*;

    logic        i_clk;
    logic        i_rstn;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    op_class_e   id_op_class;
    alu_op_e     id_alu_op;
    logic [2:0]  id_funct3;
    logic        id_illegal;

    int n_checks = 0;
    int n_errors = 0;
    int n_sent;
    int n_got;

    decode_stage #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_imm         (id_imm),
        .id_op_class    (id_op_class),
        .id_alu_op      (id_alu_op),
        .id_funct3      (id_funct3),
        .id_illegal     (id_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // present one instruction with execute ready; output is visible at the next negedge
    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_instruction = inst;
        id_ready       = 1'b1;
        @(negedge i_clk);
        if_valid       = 1'b0;
    endtask

    initial begin
        i_rstn = 1'b0; if_pc = '0; if_instruction = '0; if_valid = 1'b0;
        flush = 1'b0; id_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_id_pc",    id_pc,         32'd0);
        check("rst_id_imm",   id_imm,        32'd0);
        check("rst_id_rd",    32'(id_rd),    32'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        send(32'h0, 32'h00500093);
        check("addi_valid", 32'(id_valid),    32'd1);
        check("addi_class", 32'(id_op_class), 32'(CLS_ALUI));
        check("addi_rd",    32'(id_rd),       32'd1);
        check("addi_rs1",   32'(id_rs1),      32'd0);
        check("addi_imm",   id_imm,           32'h00000005);
        check("addi_alu",   32'(id_alu_op),   32'(ALU_ADD));

        send(32'h100, 32'hFE000EE3);
        check("beq_class",  32'(id_op_class), 32'(CLS_BRANCH));
        check("beq_imm",    id_imm,           32'hFFFFFFFC);
        check("beq_funct3", 32'(id_funct3),   32'd0);
        check("beq_pc",     id_pc,            32'h100);
        check("beq_rd",     32'(id_rd),       32'd0);

        send(32'h104, 32'h123452B7);
        check("lui_class", 32'(id_op_class), 32'(CLS_LUI));
        check("lui_rd",    32'(id_rd),       32'd5);
        check("lui_imm",   id_imm,           32'h12345000);

        send(32'h108, 32'h40208033);
        check("sub_alu", 32'(id_alu_op), 32'(ALU_SUB));
        check("sub_rs2", 32'(id_rs2),    32'd2);
        check("sub_imm", id_imm,         32'd0);

        send(32'h10C, 32'h0020A423);
        check("sw_class",  32'(id_op_class), 32'(CLS_STORE));
        check("sw_imm",    id_imm,           32'd8);
        check("sw_rd",     32'(id_rd),       32'd0);
        check("sw_funct3", 32'(id_funct3),   32'd2);

        send(32'h110, 32'h022081B3);
`ifdef RV32M_EN
        check("mul_class",   32'(id_op_class), 32'(CLS_ALU));
        check("mul_alu",     32'(id_alu_op),   32'(ALU_MUL));
        check("mul_rs1",     32'(id_rs1),      32'd1);
        check("mul_rs2",     32'(id_rs2),      32'd2);
        check("mul_rd",      32'(id_rd),       32'd3);
        check("mul_illegal", 32'(id_illegal),  32'd0);
`else
        check("mul_illegal", 32'(id_illegal),  32'd1);
        check("mul_class",   32'(id_op_class), 32'(CLS_ILLEGAL));
`endif

        send(32'h114, 32'hFFFFFFFF);
        check("ones_illegal", 32'(id_illegal),  32'd1);
        check("ones_class",   32'(id_op_class), 32'(CLS_ILLEGAL));
        check("ones_valid",   32'(id_valid),    32'd1);

        send(32'h118, 32'h00500090);
        check("lowbits_illegal", 32'(id_illegal), 32'd1);

        send(32'h11C, 32'h40001033);
        check("sll_alt_illegal", 32'(id_illegal), 32'd1);

        @(negedge i_clk);
        check("idle_valid", 32'(id_valid), 32'd0);

        // back-to-back stream with a three-cycle execute stall
        n_sent = 0;
        n_got  = 0;
        for (int cyc = 0; cyc < 40 && n_got < 4; cyc++) begin
            if_valid       = (n_sent < 4);
            if_pc          = 32'(n_sent * 4);
            if_instruction = 32'h00000013;
            id_ready       = !(cyc >= 1 && cyc <= 3);
            if (cyc == 2) check("stream_if_ready_low", 32'(if_ready), 32'd0);
            if (cyc == 3) check("stream_hold_pc", id_pc, 32'h0);
            if (cyc == 5) begin
                check("stream_if_ready_back", 32'(if_ready), 32'd1);
                check("stream_skid_out", id_pc, 32'h4);
            end
            if (id_valid && id_ready) begin
                check("stream_order", id_pc, 32'(n_got * 4));
                n_got++;
            end
            if (if_valid && if_ready) n_sent++;
            @(negedge i_clk);
        end
        if_valid = 1'b0;
        check("stream_count",   32'(n_got),    32'd4);
        check("stream_drained", 32'(id_valid), 32'd0);

        // fill output and skid, then flush with an incoming instruction
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h200; if_instruction = 32'h00000013;
        @(negedge i_clk);
        if_pc = 32'h204;
        @(negedge i_clk);
        check("flush_skid_full", 32'(if_ready), 32'd0);
        flush = 1'b1; if_pc = 32'h208;
        @(negedge i_clk);
        flush = 1'b0; if_valid = 1'b0;
        check("flush_id_valid", 32'(id_valid), 32'd0);
        check("flush_if_ready", 32'(if_ready), 32'd1);
        send(32'h20C, 32'h00000013);
        check("flush_next_valid", 32'(id_valid), 32'd1);
        check("flush_next_pc",    id_pc,         32'h20C);
        @(negedge i_clk);
        check("flush_no_stale", 32'(id_valid), 32'd0);

        // input presented in a flush cycle is discarded
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h300; id_ready = 1'b1;
        @(negedge i_clk);
        flush = 1'b0; if_valid = 1'b0;
        check("flush_drop_input", 32'(id_valid), 32'd0);

        // asynchronous reset mid-stream
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h400;
        @(negedge i_clk);
        if_pc = 32'h404;
        @(negedge i_clk);
        if_valid = 1'b0;
        #2 i_rstn = 1'b0;
        #1;
        check("arst_id_valid", 32'(id_valid), 32'd0);
        check("arst_if_ready", 32'(if_ready), 32'd1);
        check("arst_id_pc",    id_pc,         32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

RV32I decode stage between `instruction_fetch` and the execute stage. It accepts fetched (pc, instruction) pairs over a valid/ready handshake and buffers them in a one-entry skid register. It decodes register indices, the sign-extended immediate, the operation class and the ALU op, and presents the result in an output register. Supports branch-redirect flush, and back-pressure towards fetch so that the PC is held when decode is full.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `i_clk`  input  1  core clock; same clock as `instruction_fetch`.
- `i_rstn`  input  1  asynchronous, active-low reset.
- `if_pc`  input  32  PC of the fetched instruction.
- `if_instruction`  input  32  instruction word.
- `if_valid`  input  1  fetch presents a valid pair (`instruction_valid`).
- `if_ready`  output  1  decode can accept a pair this cycle.
- `flush`  input  1  redirect; discards all held and incoming instructions.
- `id_valid`  output  1  decoded output is valid.
- `id_ready`  input  1  execute consumes the output this cycle.
- `id_pc`  output  32  PC of the decoded instruction.
- `id_rs1`, `id_rs2`, `id_rd`  output  5 each  register indices; forced to 0 when the format does not use them.
- `id_imm`  output  32  sign-extended immediate (I/S/B/U/J); 0 for R-type.
- `id_op_class`  output  4  `op_class_e`.
- `id_alu_op`  output  5  `alu_op_e`.
- `id_funct3`  output  3  raw funct3, used for branch, load and store width.
- `id_illegal`  output  1  unsupported or illegal encoding.

## Operation
- An input is accepted when `if_valid && if_ready`. An output is consumed when `id_valid && id_ready`.
- The output register loads decoded data when it is empty or consumed in the same cycle.
  - The source is the skid entry if that entry is valid, otherwise the input.
  - The skid entry always has priority, so order is preserved.
- If the input is accepted while the output is held (valid and not consumed), the raw pc and instruction are stored in the skid entry.
- `if_ready = !skid_valid`, driven from a register with no combinational path from `id_ready`.
- Decode is combinational on the selected source (skid or input) and registered into the `id_*` outputs.
- Immediates:
  - I: `inst[31:20]`
  - S: `{inst[31:25],inst[11:7]}`
  - B: `{inst[31],inst[7],inst[30:25],inst[11:8],1'b0}`
  - U: `{inst[31:12],12'b0}`
  - J: `{inst[31],inst[19:12],inst[20],inst[30:21],1'b0}`
  - All are sign-extended from the top bit.
- Opcode classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALUI, ALU, FENCE, SYSTEM, ILLEGAL.
- An unknown opcode, bad funct3/funct7, or `inst[1:0] != 2'b11` gives `id_op_class = ILLEGAL` and `id_illegal = 1`. The instruction still flows through; it is not dropped.
- Flush:
  - `flush` clears `skid_valid` and `id_valid` at the next edge.
  - An input presented in the flush cycle is discarded.
  - Flush has priority over every simultaneous load.
- Reset values: `id_valid = 0`, `if_ready = 1`, all `id_*` data fields 0, `skid_valid = 0`. Reset is asynchronous, so asserting it mid-stream drops everything in flight.

## Timing
- Latency is 1 cycle from accept to `id_valid`.
- Throughput is 1 instruction per cycle while `id_ready = 1`.
- When `id_ready` is low, one further instruction is absorbed into the skid entry. `if_ready` drops on the following cycle.
- After a stall releases, the skid instruction appears on the output in the cycle after consumption, and `if_ready` returns high in that same cycle.
- After `flush`, `id_valid = 0` and `if_ready = 1` in the next cycle.
- `id_*` data is stable whenever `id_valid = 1 && id_ready = 0`.

## Configuration
- `RV32M_EN` defined:
  - OP with `funct7 = 7'b0000001` decodes as class ALU, with `alu_op` one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `RV32M_EN` undefined:
  - those encodings raise `id_illegal = 1` with class ILLEGAL.
  - the mul/div enum values remain in the package but are never emitted.

## Structure
- Package `riscv_pkg`:
  - `op_class_e` (4 bits) and `alu_op_e` (5 bits).
  - opcode constants (`OPC_LUI = 7'b0110111`, ...).
  - `decoded_t` struct grouping all `id_*` data fields.
- Sub-module `rv32_decoder`: purely combinational, instruction to `decoded_t`. Its `` `ifdef `` section holds the RV32M decoding.
- The top level holds the skid and output registers, the handshake and the flush logic.

## Test plan
- `0x00500093` (addi x1,x0,5), `id_ready = 1` -> 1 cycle later: `id_valid = 1`, class ALUI, `rd = 1`, `rs1 = 0`, `imm = 0x00000005`, `alu_op = ADD`.
- `0xFE000EE3` (beq x0,x0,-4) at `pc = 0x100` -> class BRANCH, `imm = 0xFFFFFFFC`, `funct3 = 0`, `id_pc = 0x100`, `rd = 0`.
- `0x123452B7` (lui x5) -> class LUI, `rd = 5`, `imm = 0x12345000`.
- Back-to-back stream pc 0x0, 0x4, 0x8, 0xC with `id_ready` low for 3 cycles -> `if_ready` falls after the skid fills. After release, outputs appear in order 0x0, 0x4, 0x8, 0xC with none lost or duplicated.
- Skid full, then `flush` together with `if_valid` -> next cycle `id_valid = 0`, `if_ready = 1`. The next accepted pc is the first one shown at the output.
- `0x022081B3` (mul x3,x1,x2):
  - with `RV32M_EN` -> class ALU, `alu_op = MUL`, `rs1 = 1`, `rs2 = 2`, `rd = 3`.
  - without -> `id_illegal = 1`.
  - `0xFFFFFFFF` -> `id_illegal = 1` in both builds.
